// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: write-back sequencer for the multicycle CPU register file.
// On start it latches opcode/funct and classifies the instruction. It selects
// the destination register and the write-data source, waits for memory or for
// the mult/div unit, then emits a single regWrite strobe and a done pulse.
// Optional feature macro: WB_TIMEOUT_EN adds a WAIT_MDU watchdog (TIMEOUT).
module regfile_wb_ctrl #(
  parameter int          MEM_LAT = 2,
  parameter logic [5:0]  SP_OP   = 6'h3E,
  parameter logic [5:0]  RS_OP   = 6'h3F
`ifdef WB_TIMEOUT_EN
  , parameter int        TIMEOUT = 64
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mdu_busy,
  output logic [2:0] regDSTmux,
  output logic [2:0] wb_src,
  output logic       regWrite,
  output logic       done,
  output logic       illegal,
  output logic       timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_WAIT_MEM, S_WAIT_MDU, S_WRITE, S_DONE
  } state_t;

  // Decoder result: selects, illegal flag, and the state following DECODE.
  typedef struct packed {
    logic [2:0] dst;
    logic [2:0] src;
    logic       ill;
    state_t     nxt;
  } dec_t;

  localparam logic [2:0] DST_RT = 3'b000, DST_RD = 3'b001, DST_SP = 3'b010,
                         DST_RA = 3'b011, DST_RS = 3'b100;
  localparam logic [2:0] SRC_ALU = 3'b000, SRC_MDR = 3'b001, SRC_HI = 3'b010,
                         SRC_LO  = 3'b011, SRC_PC  = 3'b100;
  localparam logic [3:0] MEM_CNT0 = 4'(MEM_LAT - 1);

  state_t     state, state_nxt;
  logic [5:0] op_q, fn_q;
  logic [2:0] dst_q, src_q;
  logic [3:0] mem_cnt;
  logic       ill_q;
  logic       to_q;
  logic       mdu_to;
  dec_t       dec;

  // Classify the latched instruction.
  always_comb begin
    dec = '{dst: DST_RT, src: SRC_ALU, ill: 1'b0, nxt: S_DONE};
    if (op_q == 6'h00) begin
      case (fn_q)
        6'h10:                             dec = '{DST_RD, SRC_HI,  1'b0, S_WAIT_MDU};
        6'h12:                             dec = '{DST_RD, SRC_LO,  1'b0, S_WAIT_MDU};
        6'h09:                             dec = '{DST_RD, SRC_PC,  1'b0, S_WRITE};
        6'h08, 6'h18, 6'h19, 6'h1A, 6'h1B: dec.nxt = S_DONE;
        6'h20, 6'h22, 6'h24, 6'h25, 6'h2A,
        6'h00, 6'h02, 6'h03, 6'h27:        dec = '{DST_RD, SRC_ALU, 1'b0, S_WRITE};
        default:                           dec.ill = 1'b1;
      endcase
    end else begin
      case (op_q)
        6'h23, 6'h20, 6'h21:               dec = '{DST_RT, SRC_MDR, 1'b0, S_WAIT_MEM};
        6'h08, 6'h09, 6'h0A,
        6'h0C, 6'h0D, 6'h0F:               dec = '{DST_RT, SRC_ALU, 1'b0, S_WRITE};
        6'h03:                             dec = '{DST_RA, SRC_PC,  1'b0, S_WRITE};
        SP_OP:                             dec = '{DST_SP, SRC_ALU, 1'b0, S_WRITE};
        RS_OP:                             dec = '{DST_RS, SRC_ALU, 1'b0, S_WRITE};
        6'h02, 6'h04, 6'h05,
        6'h2B, 6'h28, 6'h29:               dec.nxt = S_DONE;
        default:                           dec.ill = 1'b1;
      endcase
    end
  end

`ifdef WB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] mdu_cnt;

  assign mdu_to = (state == S_WAIT_MDU) && mdu_busy && (mdu_cnt == TW'(TIMEOUT - 1));

  // Watchdog: count busy cycles in WAIT_MDU; remember a firing until IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      mdu_cnt <= '0;
      to_q    <= 1'b0;
    end else begin
      if (state == S_DECODE)                   mdu_cnt <= '0;
      else if (state == S_WAIT_MDU && mdu_busy) mdu_cnt <= mdu_cnt + 1'b1;
      if (state == S_IDLE)  to_q <= 1'b0;
      else if (mdu_to)      to_q <= 1'b1;
    end
  end
`else
  assign mdu_to = 1'b0;
  assign to_q   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start) state_nxt = S_DECODE;
      S_DECODE:   state_nxt = dec.nxt;
      S_WAIT_MEM: if (mem_cnt == 4'd0) state_nxt = S_WRITE;
      S_WAIT_MDU: if (mdu_to) state_nxt = S_DONE;
                  else if (!mdu_busy) state_nxt = S_WRITE;
      S_WRITE:    state_nxt = S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Instruction latch, selects held DECODE..DONE, memory latency counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= '0;
      fn_q    <= '0;
      dst_q   <= DST_RT;
      src_q   <= SRC_ALU;
      ill_q   <= 1'b0;
      mem_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          ill_q <= 1'b0;
          if (start) begin
            op_q <= opcode;
            fn_q <= funct;
          end
        end
        S_DECODE: begin
          dst_q   <= dec.dst;
          src_q   <= dec.src;
          ill_q   <= dec.ill;
          mem_cnt <= MEM_CNT0;
        end
        S_WAIT_MEM: if (mem_cnt != 4'd0) mem_cnt <= mem_cnt - 4'd1;
        S_DONE: begin
          dst_q <= DST_RT;
          src_q <= SRC_ALU;
        end
        default: ;
      endcase
    end
  end

  // Moore outputs.
  always_comb begin
    regDSTmux = dst_q;
    wb_src    = src_q;
    regWrite  = (state == S_WRITE);
    done      = (state == S_DONE);
    illegal   = (state == S_DONE) && ill_q;
    timeout   = (state == S_DONE) && to_q;
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed vector table, hand-written
// reset sequences, and randomized transactions against a transaction-level model.
module tb_regfile_wb_ctrl;

  localparam int MEM_LAT = 2;
  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       reset, start, mdu_busy;
  logic [5:0] opcode, funct;
  logic [2:0] regDSTmux, wb_src;
  logic       regWrite, done, illegal, timeout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_wb_ctrl #(.MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .funct(funct),
    .mdu_busy(mdu_busy), .regDSTmux(regDSTmux), .wb_src(wb_src),
    .regWrite(regWrite), .done(done), .illegal(illegal), .timeout(timeout)
  );

  typedef struct {
    logic [5:0] op, fn;
    int         b, rk;
    int         dst, src, wr, lat, ill;
  } vec_t;

  typedef struct {
    int dst, src, wr, lat, ill, to;
  } exp_t;

  typedef struct {
    int rw_cnt, rw_cyc, done_cyc, dst, src, ill, to;
  } obs_t;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Transaction-level reference: what the instruction writes and when it retires.
  function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn, input int b);
    exp_t e;
    e = '{dst: 0, src: 0, wr: 0, lat: 2, ill: 0, to: 0};
    if (op == 6'h00) begin
      case (fn)
        6'h10, 6'h12: begin
          e.dst = 1; e.src = (fn == 6'h10) ? 2 : 3; e.wr = 1; e.lat = 4 + b;
`ifdef WB_TIMEOUT_EN
          if (b >= TIMEOUT) begin e.wr = 0; e.to = 1; e.lat = 2 + TIMEOUT; end
`endif
        end
        6'h09: begin e.dst = 1; e.src = 4; e.wr = 1; e.lat = 3; end
        6'h08, 6'h18, 6'h19, 6'h1A, 6'h1B: ;
        6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h03, 6'h27:
          begin e.dst = 1; e.wr = 1; e.lat = 3; end
        default: e.ill = 1;
      endcase
    end else begin
      case (op)
        6'h23, 6'h20, 6'h21: begin e.src = 1; e.wr = 1; e.lat = 3 + MEM_LAT; end
        6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F: begin e.wr = 1; e.lat = 3; end
        6'h03: begin e.dst = 3; e.src = 4; e.wr = 1; e.lat = 3; end
        6'h3E: begin e.dst = 2; e.wr = 1; e.lat = 3; end
        6'h3F: begin e.dst = 4; e.wr = 1; e.lat = 3; end
        6'h02, 6'h04, 6'h05, 6'h2B, 6'h28, 6'h29: ;
        default: e.ill = 1;
      endcase
    end
    return e;
  endfunction

  // Issue one instruction at a negedge and observe until done (bounded).
  // Cycle k is the k-th cycle after the start-sampling edge; b = busy cycles
  // seen in WAIT_MDU; rk = cycle in which a stray start pulse is driven.
  task automatic run_txn(input logic [5:0] op, input logic [5:0] fn,
                         input int b, input int rk, output obs_t o);
    int k;
    o = '{rw_cnt: 0, rw_cyc: -1, done_cyc: -1, dst: 0, src: 0, ill: 0, to: 0};
    opcode = op; funct = fn; start = 1'b1; mdu_busy = 1'b1;
    k = 0;
    while (k < 300) begin
      @(posedge clk); @(negedge clk); k++;
      start    = (k == rk);
      opcode   = ~op;
      funct    = ~fn;
      mdu_busy = (k < 2 + b);
      if (regWrite) begin o.rw_cnt++; o.rw_cyc = k; end
      if (done) begin
        o.done_cyc = k; o.dst = regDSTmux; o.src = wb_src;
        o.ill = illegal; o.to = timeout;
        break;
      end
    end
    start = 1'b0; mdu_busy = 1'b0;
  endtask

  task automatic check_txn(input string tag, input obs_t o, input exp_t e);
    chk({tag, " done_cyc"}, o.done_cyc, e.lat);
    chk({tag, " rw_cnt"}, o.rw_cnt, e.wr);
    if (e.wr != 0) chk({tag, " rw_cyc"}, o.rw_cyc, e.lat - 1);
    if (e.wr != 0 || e.ill != 0) begin
      chk({tag, " dst"}, o.dst, e.dst);
      chk({tag, " src"}, o.src, e.src);
    end
    chk({tag, " illegal"}, o.ill, e.ill);
    chk({tag, " timeout"}, o.to, e.to);
    // the cycle after done must be quiet
    @(posedge clk); @(negedge clk);
    chk({tag, " idle"}, {regWrite, done, illegal, timeout}, 0);
  endtask

  vec_t vecs[14];
  logic [5:0] ops[20] = '{6'h00, 6'h23, 6'h20, 6'h21, 6'h08, 6'h09, 6'h0A, 6'h0C,
                          6'h0D, 6'h0F, 6'h03, 6'h3E, 6'h3F, 6'h02, 6'h04, 6'h05,
                          6'h2B, 6'h28, 6'h29, 6'h3A};
  logic [5:0] fns[16] = '{6'h10, 6'h12, 6'h09, 6'h08, 6'h18, 6'h19, 6'h1A, 6'h1B,
                          6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h27, 6'h3F};

  initial begin
    obs_t o;
    exp_t e;
    logic [5:0] op, fn;
    int b, rk;

    //            op     fn     b  rk dst src wr lat ill
    vecs[0]  = '{6'h00, 6'h20, 0, 0, 1, 0, 1, 3, 0};
    vecs[1]  = '{6'h23, 6'h00, 0, 0, 0, 1, 1, 5, 0};
    vecs[2]  = '{6'h00, 6'h10, 5, 0, 1, 2, 1, 9, 0};
    vecs[3]  = '{6'h00, 6'h12, 0, 0, 1, 3, 1, 4, 0};
    vecs[4]  = '{6'h03, 6'h00, 0, 0, 3, 4, 1, 3, 0};
    vecs[5]  = '{6'h3E, 6'h00, 0, 0, 2, 0, 1, 3, 0};
    vecs[6]  = '{6'h3F, 6'h00, 0, 0, 4, 0, 1, 3, 0};
    vecs[7]  = '{6'h2B, 6'h00, 0, 0, 0, 0, 0, 2, 0};
    vecs[8]  = '{6'h3A, 6'h00, 0, 0, 0, 0, 0, 2, 1};
    vecs[9]  = '{6'h00, 6'h09, 0, 0, 1, 4, 1, 3, 0};
    vecs[10] = '{6'h00, 6'h18, 0, 0, 0, 0, 0, 2, 0};
    vecs[11] = '{6'h0F, 6'h00, 0, 0, 0, 0, 1, 3, 0};
    vecs[12] = '{6'h23, 6'h00, 0, 2, 0, 1, 1, 5, 0};
    vecs[13] = '{6'h00, 6'h3F, 0, 0, 0, 0, 0, 2, 1};

    reset = 1'b1; start = 1'b0; mdu_busy = 1'b0; opcode = '0; funct = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("reset outputs", {regDSTmux, wb_src, regWrite, done, illegal, timeout}, 0);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("post-reset idle", {regWrite, done}, 0);

    foreach (vecs[i]) begin
      run_txn(vecs[i].op, vecs[i].fn, vecs[i].b, vecs[i].rk, o);
      e = '{dst: vecs[i].dst, src: vecs[i].src, wr: vecs[i].wr,
            lat: vecs[i].lat, ill: vecs[i].ill, to: 0};
      check_txn($sformatf("vec%0d", i), o, e);
    end

    // Reset asserted while in WRITE: next cycle shows reset values, no strobe.
    opcode = 6'h00; funct = 6'h20; start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_in_write pre", regWrite, 1);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_in_write outs", {regDSTmux, wb_src, regWrite, done, illegal, timeout}, 0);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_in_write after", {regWrite, done}, 0);

    // Long busy: plain wait in default build, watchdog in the timeout build.
    run_txn(6'h00, 6'h10, 70, 0, o);
    check_txn("mdu_long", o, model(6'h00, 6'h10, 70));

    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 19)];
      fn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fns[$urandom_range(0, 15)];
      b  = $urandom_range(0, 6);
      rk = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0;
      run_txn(op, fn, b, rk, o);
      check_txn($sformatf("rnd%0d op%h fn%h", n, op, fn), o, model(op, fn, b));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
